// File: rtl/adc_channel_responder.sv
// ADC0808-style responder: answers start/address/oe with per-channel values from a writable
// table after CONV_CYCLES rising edges of the (sampled) adc_clk.
module adc_channel_responder #(
   parameter int                NUM_CH      = 8,
   parameter int                ADDR_W      = 3,
   parameter int                DATA_W      = 8,
   parameter int                CONV_CYCLES = 8,
   parameter logic [DATA_W-1:0] RESET_VAL   = 8'hFF
) (
   input  logic              CLK100MHZ,
   input  logic              reset,
   input  logic              adc_clk,
   input  logic              start,
   input  logic [ADDR_W-1:0] address,
   input  logic              oe,
   output logic [DATA_W-1:0] digital_out,
   output logic              eoc,
   output logic              busy,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_ch,
   input  logic [DATA_W-1:0] cfg_data,
   output logic [15:0]       conv_count
);

   localparam int               CNT_W    = $clog2(CONV_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LATCH   = 2'd1;
   localparam logic [1:0] S_CONVERT = 2'd2;

   logic              start_s1, start_s2, start_s3;
   logic              adc_s1, adc_s2, adc_s3;
   logic              start_rise, adc_rise;
   logic [1:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] snap;
   logic [DATA_W-1:0] snap_fwd;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] table_q [NUM_CH];

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         start_s1 <= 1'b0;
         start_s2 <= 1'b0;
         start_s3 <= 1'b0;
         adc_s1   <= 1'b0;
         adc_s2   <= 1'b0;
         adc_s3   <= 1'b0;
      end else begin
         start_s1 <= start;
         start_s2 <= start_s1;
         start_s3 <= start_s2;
         adc_s1   <= adc_clk;
         adc_s2   <= adc_s1;
         adc_s3   <= adc_s2;
      end
   end

   assign start_rise = start_s2 & ~start_s3;
   assign adc_rise   = adc_s2 & ~adc_s3;

   // NOTE: the table must come out of reset at RESET_VAL, so it is a flop array rather than a RAM.
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) table_q[i] <= RESET_VAL;
      end else if (cfg_we) begin
         table_q[cfg_ch] <= cfg_data;
      end
   end

   // A write landing in the snapshot cycle for the same channel is seen by the conversion.
   assign snap_fwd = (cfg_we && (cfg_ch == addr_q)) ? cfg_data : table_q[addr_q];

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         state      <= S_IDLE;
         addr_q     <= '0;
         cnt        <= '0;
         snap       <= '0;
         result     <= '0;
         conv_count <= '0;
      end else if (start_rise) begin
         addr_q <= address;
         cnt    <= '0;
         state  <= S_LATCH;
      end else begin
         case (state)
            S_LATCH: begin
               snap  <= snap_fwd;
               cnt   <= '0;
               state <= S_CONVERT;
            end
            S_CONVERT: begin
               if (adc_rise) begin
                  if (cnt == CNT_LAST) begin
                     result     <= snap;
                     conv_count <= conv_count + 16'd1;
                     state      <= S_IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (reset) digital_out <= '0;
      else       digital_out <= oe ? result : '0;
   end

   assign eoc  = (state == S_IDLE);
   assign busy = (state == S_LATCH) || (state == S_CONVERT);

endmodule

// File: tb/tb_adc_channel_responder.sv
// Directed bench for adc_channel_responder with CONV_CYCLES=4; inputs driven and outputs
// sampled on the falling edge of CLK100MHZ.
module tb_adc_channel_responder;

   localparam int CONV = 4;

   logic        CLK100MHZ = 1'b0;
   logic        reset     = 1'b1;
   logic        adc_clk   = 1'b0;
   logic        start     = 1'b0;
   logic [2:0]  address   = 3'd0;
   logic        oe        = 1'b0;
   logic        cfg_we    = 1'b0;
   logic [2:0]  cfg_ch    = 3'd0;
   logic [7:0]  cfg_data  = 8'd0;
   logic [7:0]  digital_out;
   logic        eoc;
   logic        busy;
   logic [15:0] conv_count;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [15:0] exp_count   = 16'd0;

   adc_channel_responder #(
      .NUM_CH(8), .ADDR_W(3), .DATA_W(8), .CONV_CYCLES(CONV), .RESET_VAL(8'hFF)
   ) dut (
      .CLK100MHZ  (CLK100MHZ),
      .reset      (reset),
      .adc_clk    (adc_clk),
      .start      (start),
      .address    (address),
      .oe         (oe),
      .digital_out(digital_out),
      .eoc        (eoc),
      .busy       (busy),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_data   (cfg_data),
      .conv_count (conv_count)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(negedge CLK100MHZ);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(3);
      reset = 1'b0;
      exp_count = 16'd0;
   endtask

   task automatic write_cfg(input logic [2:0] ch, input logic [7:0] data);
      cfg_we = 1'b1; cfg_ch = ch; cfg_data = data;
      step(1);
      cfg_we = 1'b0;
   endtask

   // Leaves the DUT in LATCH: three edges through sync, edge detect and FSM.
   task automatic launch(input logic [2:0] ch);
      address = ch;
      start = 1'b1;
      step(3);
      start = 1'b0;
   endtask

   task automatic adc_pulse();
      adc_clk = 1'b1;
      step(4);
      adc_clk = 1'b0;
      step(4);
   endtask

   task automatic wait_eoc(input string name);
      int n = 0;
      while (eoc !== 1'b1 && n < 40) begin
         step(1);
         n++;
      end
      vectors++;
      if (eoc !== 1'b1) begin
         miscompares++;
         $display("FAIL %s eoc timeout: got %b want 1", name, eoc);
      end
   endtask

   task automatic convert(input logic [2:0] ch, input string name);
      launch(ch);
      repeat (CONV) adc_pulse();
      wait_eoc(name);
      exp_count++;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (eoc !== 1'b1) begin miscompares++; $display("FAIL reset_eoc: got %b want 1", eoc); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (digital_out !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h want 00", digital_out); end
      vectors++; if (conv_count !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", conv_count); end
      oe = 1'b1;
      step(1);
      vectors++; if (digital_out !== 8'h00) begin miscompares++; $display("FAIL reset_oe_dout: got %h want 00", digital_out); end
      convert(3'd0, "reset_conv");
      step(1);
      vectors++; if (digital_out !== 8'hFF) begin miscompares++; $display("FAIL reset_default_ch0: got %h want ff", digital_out); end
      vectors++; if (conv_count !== exp_count) begin miscompares++; $display("FAIL reset_conv_count: got %0d want %0d", conv_count, exp_count); end
   endtask

   task automatic test_single();
      oe = 1'b0;
      do_reset();
      write_cfg(3'd5, 8'h42);
      address = 3'd5;
      start = 1'b1;
      step(2);
      vectors++; if (eoc !== 1'b1) begin miscompares++; $display("FAIL single_eoc_t2: got %b want 1", eoc); end
      step(1);
      vectors++; if (eoc !== 1'b0) begin miscompares++; $display("FAIL single_eoc_t3: got %b want 0", eoc); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_t3: got %b want 1", busy); end
      start = 1'b0;
      address = 3'd1;
      repeat (CONV - 1) adc_pulse();
      vectors++; if (eoc !== 1'b0) begin miscompares++; $display("FAIL single_eoc_early: got %b want 0", eoc); end
      adc_pulse();
      exp_count++;
      vectors++; if (eoc !== 1'b1) begin miscompares++; $display("FAIL single_eoc_done: got %b want 1", eoc); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_done: got %b want 0", busy); end
      vectors++; if (conv_count !== 16'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", conv_count); end
      oe = 1'b1;
      vectors++; if (digital_out !== 8'h00) begin miscompares++; $display("FAIL single_dout_before: got %h want 00", digital_out); end
      step(1);
      vectors++; if (digital_out !== 8'h42) begin miscompares++; $display("FAIL single_dout_after: got %h want 42", digital_out); end
   endtask

   task automatic test_sweep();
      logic [7:0] v;
      do_reset();
      oe = 1'b1;
      for (int i = 0; i < 8; i++) write_cfg(3'(i), 8'(10 * i));
      for (int i = 0; i < 8; i++) begin
         v = 8'(10 * i);
         convert(3'(i), "sweep");
         step(1);
         vectors++;
         if (digital_out !== v) begin
            miscompares++;
            $display("FAIL sweep_ch%0d: got %0d want %0d", i, digital_out, v);
         end
      end
      vectors++; if (conv_count !== 16'd8) begin miscompares++; $display("FAIL sweep_count: got %0d want 8", conv_count); end
   endtask

   task automatic test_restart();
      write_cfg(3'd2, 8'h11);
      write_cfg(3'd6, 8'h99);
      launch(3'd2);
      repeat (2) adc_pulse();
      vectors++; if (eoc !== 1'b0) begin miscompares++; $display("FAIL restart_eoc_mid: got %b want 0", eoc); end
      launch(3'd6);
      vectors++; if (eoc !== 1'b0) begin miscompares++; $display("FAIL restart_eoc_latch: got %b want 0", eoc); end
      repeat (CONV - 1) adc_pulse();
      vectors++; if (eoc !== 1'b0) begin miscompares++; $display("FAIL restart_eoc_early: got %b want 0", eoc); end
      vectors++; if (conv_count !== exp_count) begin miscompares++; $display("FAIL restart_count_early: got %0d want %0d", conv_count, exp_count); end
      adc_pulse();
      exp_count++;
      vectors++; if (eoc !== 1'b1) begin miscompares++; $display("FAIL restart_eoc_done: got %b want 1", eoc); end
      vectors++; if (conv_count !== exp_count) begin miscompares++; $display("FAIL restart_count: got %0d want %0d", conv_count, exp_count); end
      vectors++; if (digital_out !== 8'h99) begin miscompares++; $display("FAIL restart_result: got %h want 99", digital_out); end
   endtask

   task automatic test_collision();
      address = 3'd3;
      start = 1'b1;
      step(3);
      start = 1'b0;
      // DUT is in LATCH now: this write lands in the snapshot cycle.
      write_cfg(3'd3, 8'h07);
      adc_pulse();
      write_cfg(3'd3, 8'h55);
      repeat (CONV - 1) adc_pulse();
      wait_eoc("collision");
      exp_count++;
      step(1);
      vectors++; if (digital_out !== 8'h07) begin miscompares++; $display("FAIL collision_result: got %h want 07", digital_out); end
      convert(3'd3, "collision_reread");
      step(1);
      vectors++; if (digital_out !== 8'h55) begin miscompares++; $display("FAIL collision_late_write: got %h want 55", digital_out); end
      vectors++; if (conv_count !== exp_count) begin miscompares++; $display("FAIL collision_count: got %0d want %0d", conv_count, exp_count); end
   endtask

   task automatic test_reset_mid_convert();
      write_cfg(3'd1, 8'hAB);
      launch(3'd1);
      repeat (2) adc_pulse();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      exp_count = 16'd0;
      vectors++; if (eoc !== 1'b1) begin miscompares++; $display("FAIL midreset_eoc: got %b want 1", eoc); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy); end
      vectors++; if (conv_count !== 16'd0) begin miscompares++; $display("FAIL midreset_count: got %0d want 0", conv_count); end
      vectors++; if (digital_out !== 8'h00) begin miscompares++; $display("FAIL midreset_dout: got %h want 00", digital_out); end
      repeat (2) adc_pulse();
      vectors++; if (conv_count !== 16'd0) begin miscompares++; $display("FAIL midreset_no_resume: got %0d want 0", conv_count); end
      convert(3'd1, "midreset_conv");
      step(1);
      vectors++; if (digital_out !== 8'hFF) begin miscompares++; $display("FAIL midreset_table: got %h want ff", digital_out); end
      vectors++; if (conv_count !== 16'd1) begin miscompares++; $display("FAIL midreset_count_after: got %0d want 1", conv_count); end
   endtask

   initial begin
      step(1);
      test_reset();
      test_single();
      test_sweep();
      test_restart();
      test_collision();
      test_reset_mid_convert();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
